// File: rtl/hilo_pkg.sv
// Shared HI/LO unit definitions: op codes, FSM states, accumulate modes and decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hilo_pkg;

  // Operation codes carried on the 4-bit op bus; codes 10..15 are undefined and act as no-ops
  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DZERO
  } state_e;

  // What a multiply-class op does with the existing {hi,lo} value
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } acc_e;

  // True for every op that reads or writes HI/LO; the hazard unit stalls on busy & is_hilo_op(op)
  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op <= OP_MTLO);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Iterative unsigned restoring divider, DIV_BITS quotient bits retired per cycle.
// Latency: WIDTH/DIV_BITS cycles after start; done is high during the final iteration cycle.
// Backpressure: none; start is only honoured by the parent when idle, cancel aborts at the next edge.
module hilo_div_core #(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int ITERS = WIDTH / DIV_BITS;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH:0]   trial;

  // One iteration: shift the next dividend bit into the partial remainder, subtract if it fits
  always_comb begin
    rem_nx = rem_q;
    quo_nx = quo_q;
    trial  = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial  = {rem_nx, quo_nx[WIDTH-1]};
      quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dsr_q}) begin
        trial     = trial - {1'b0, dsr_q};
        quo_nx[0] = 1'b1;
      end
      rem_nx = trial[WIDTH-1:0];
    end
  end

  // The iteration now in progress is the last one; results land in quo_q/rem_q at this edge
  assign done      = running & (cnt == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Load operands on start, then step the remainder/quotient shift registers until the count expires
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
    end else if (cancel) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= dividend;
      dsr_q   <= divisor;
    end else if (running) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt   <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// MIPS32 HI/LO unit: owns HI/LO, runs MT*, multiply/accumulate and divide ops.
// Latency: MT* 0 edges, multiply class MUL_LATENCY edges, divide WIDTH/DIV_BITS+1 edges, divide-by-zero 1 edge.
// Backpressure: in_ready only in IDLE; cancel aborts any in-flight op without writing HI/LO.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIV_BITS    = 1,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY + 1) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_LATENCY);

  state_e           state;
  logic [MCW-1:0]   mul_cnt;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             sgn_q;
  acc_e             acc_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_start;
  logic             core_done;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;

  assign in_ready = (state == ST_IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready & ~cancel;

  // Only DIV is signed; DIVU magnitudes are the raw operands. -MIN wraps to MIN, which as an
  // unsigned magnitude is exactly right.
  assign a_neg  = (op == OP_DIV) & a[WIDTH-1];
  assign b_neg  = (op == OP_DIV) & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  assign div_start = accept & is_div_op(op) & ~b_zero;

  hilo_div_core #(
    .WIDTH    (WIDTH),
    .DIV_BITS (DIV_BITS)
  ) u_div_core (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (div_start),
    .cancel    (cancel),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign
  assign fix_q = q_neg_q ? -core_q : core_q;
  assign fix_r = r_neg_q ? -core_r : core_r;

  // Full-width product from the captured operands. HI/LO cannot change while in MUL, so the
  // live {hi,lo} equals the value present at the accept edge and serves as the accumulator.
  always_comb begin
    ext_a      = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
    ext_b      = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
    product    = ext_a * ext_b;
    mul_result = product;
    case (acc_q)
      ACC_ADD: mul_result = {hi, lo} + product;
      ACC_SUB: mul_result = {hi, lo} - product;
      default: mul_result = product;
    endcase
  end

  // Control FSM with registered HI/LO, done and div_zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mul_cnt  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= ACC_NONE;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && cancel) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              div_zero <= 1'b0;
              opa_q    <= a;
              opb_q    <= b;
              mul_cnt  <= MCW'(1);
              case (op)
                OP_MULT:  begin state <= ST_MUL; sgn_q <= 1'b1; acc_q <= ACC_NONE; end
                OP_MULTU: begin state <= ST_MUL; sgn_q <= 1'b0; acc_q <= ACC_NONE; end
                OP_MADD:  begin state <= ST_MUL; sgn_q <= 1'b1; acc_q <= ACC_ADD;  end
                OP_MADDU: begin state <= ST_MUL; sgn_q <= 1'b0; acc_q <= ACC_ADD;  end
                OP_MSUB:  begin state <= ST_MUL; sgn_q <= 1'b1; acc_q <= ACC_SUB;  end
                OP_MSUBU: begin state <= ST_MUL; sgn_q <= 1'b0; acc_q <= ACC_SUB;  end
                OP_DIV, OP_DIVU: begin
                  q_neg_q <= a_neg ^ b_neg;
                  r_neg_q <= a_neg;
                  state   <= b_zero ? ST_DZERO : ST_DIV;
                end
                OP_MTHI:  hi <= a;
                OP_MTLO:  lo <= a;
                default:  ;
              endcase
            end
          end
          ST_MUL: begin
            if (mul_cnt == MUL_LAST) begin
              {hi, lo} <= mul_result;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              mul_cnt <= mul_cnt + 1'b1;
            end
          end
          ST_DIV: begin
            if (core_done) state <= ST_FIX;
          end
          ST_FIX: begin
            lo    <= fix_q;
            hi    <= fix_r;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          ST_DZERO: begin
            lo       <= '1;
            hi       <= opa_q;
            div_zero <= 1'b1;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: two instances (DIV_BITS=1 and DIV_BITS=2, MUL_LATENCY=2).
// Latency: checks exact edge counts for MT, multiply, divide and divide-by-zero.
// Backpressure: exercises busy rejection, cancel in flight and cancel in IDLE.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        in_valid1, in_valid2;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        cancel;

  logic        in_ready1, busy1, done1, div_zero1;
  logic [31:0] hi1, lo1;
  logic        in_ready2, busy2, done2, div_zero2;
  logic [31:0] hi2, lo2;

  int n_cmp = 0;
  int n_bad = 0;
  int done1_cnt = 0;
  int done2_cnt = 0;

  hilo_muldiv_unit #(.WIDTH(32), .DIV_BITS(1), .MUL_LATENCY(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .cancel(cancel), .hi(hi1), .lo(lo1),
    .busy(busy1), .done(done1), .div_zero(div_zero1)
  );

  hilo_muldiv_unit #(.WIDTH(32), .DIV_BITS(2), .MUL_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .cancel(cancel), .hi(hi2), .lo(lo2),
    .busy(busy2), .done(done2), .div_zero(div_zero2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count done pulses mid-cycle, away from the active edge
  always @(negedge clock) begin
    if (done1) done1_cnt <= done1_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one op for a single cycle to the selected instances; returns 1 time unit after the accept edge
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic v1, input logic v2);
    op = o; a = x; b = y; in_valid1 = v1; in_valid2 = v2;
    step(1);
    in_valid1 = 1'b0; in_valid2 = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(2);
    n_cmp++; if ({hi1, lo1} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo1: got %h want %h", {hi1, lo1}, 64'h0); end
    n_cmp++; if ({hi2, lo2} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo2: got %h want %h", {hi2, lo2}, 64'h0); end
    n_cmp++; if ({in_ready1, busy1, done1, div_zero1} !== 4'b1000) begin n_bad++; $display("FAIL reset_flags1: got %b want %b", {in_ready1, busy1, done1, div_zero1}, 4'b1000); end
    n_cmp++; if ({in_ready2, busy2, done2, div_zero2} !== 4'b1000) begin n_bad++; $display("FAIL reset_flags2: got %b want %b", {in_ready2, busy2, done2, div_zero2}, 4'b1000); end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_mt;
    int d0;
    d0 = done1_cnt;
    issue(OP_MTHI, 32'h12345678, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (hi1 !== 32'h12345678) begin n_bad++; $display("FAIL mthi_hi: got %h want %h", hi1, 32'h12345678); end
    n_cmp++; if (lo1 !== 32'h0) begin n_bad++; $display("FAIL mthi_lo: got %h want %h", lo1, 32'h0); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b want 0", busy1); end
    issue(OP_MTLO, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (lo1 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mtlo_lo: got %h want %h", lo1, 32'hCAFEF00D); end
    step(2);
    n_cmp++; if (done1_cnt - d0 !== 0) begin n_bad++; $display("FAIL mt_no_done: got %0d pulses want 0", done1_cnt - d0); end
  endtask

  task automatic test_mult_madd;
    int d0;
    d0 = done1_cnt;
    issue(OP_MULT, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b0);
    step(1);
    n_cmp++; if ({hi1, lo1} !== 64'h12345678_CAFEF00D) begin n_bad++; $display("FAIL mult_early: got %h want %h", {hi1, lo1}, 64'h12345678_CAFEF00D); end
    n_cmp++; if (in_ready1 !== 1'b0) begin n_bad++; $display("FAIL mult_ready_busy: got %b want 0", in_ready1); end
    step(1);
    n_cmp++; if ({hi1, lo1} !== 64'hFFFFFFFF_FFFFFFFE) begin n_bad++; $display("FAIL mult_result: got %h want %h", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFFE); end
    n_cmp++; if ({done1, in_ready1} !== 2'b11) begin n_bad++; $display("FAIL mult_done_ready: got %b want 11", {done1, in_ready1}); end
    // Back-to-back issue in the done cycle
    issue(OP_MADD, 32'h3, 32'h4, 1'b1, 1'b0);
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b want 0", done1); end
    step(2);
    n_cmp++; if ({hi1, lo1} !== 64'h00000000_0000000A) begin n_bad++; $display("FAIL madd_result: got %h want %h", {hi1, lo1}, 64'hA); end
    step(1);
    n_cmp++; if (done1_cnt - d0 !== 2) begin n_bad++; $display("FAIL mul_done_count: got %0d want 2", done1_cnt - d0); end
  endtask

  task automatic test_mul_variants;
    issue(OP_MULT, 32'hFFFFFFFD, 32'h5, 1'b1, 1'b0);
    step(2);
    n_cmp++; if ({hi1, lo1} !== 64'hFFFFFFFF_FFFFFFF1) begin n_bad++; $display("FAIL mult_neg: got %h want %h", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFF1); end
    issue(OP_MSUB, 32'h2, 32'h3, 1'b1, 1'b0);
    step(2);
    n_cmp++; if ({hi1, lo1} !== 64'hFFFFFFFF_FFFFFFEB) begin n_bad++; $display("FAIL msub: got %h want %h", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFEB); end
    issue(OP_MADDU, 32'h80000000, 32'h2, 1'b1, 1'b0);
    step(2);
    n_cmp++; if ({hi1, lo1} !== 64'h00000000_FFFFFFEB) begin n_bad++; $display("FAIL maddu: got %h want %h", {hi1, lo1}, 64'h00000000_FFFFFFEB); end
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    step(2);
    n_cmp++; if ({hi1, lo1} !== 64'hFFFFFFFE_00000001) begin n_bad++; $display("FAIL multu: got %h want %h", {hi1, lo1}, 64'hFFFFFFFE_00000001); end
    issue(4'hF, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    n_cmp++; if ({busy1, hi1, lo1} !== {1'b0, 64'hFFFFFFFE_00000001}) begin n_bad++; $display("FAIL undef_op: got %b %h want 0 %h", busy1, {hi1, lo1}, 64'hFFFFFFFE_00000001); end
  endtask

  task automatic test_div;
    // -7 / 2 on both instances
    issue(OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b1, 1'b1);
    step(16);
    n_cmp++; if ({busy2, lo2} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL div2_early: got %b %h want 1 %h", busy2, lo2, 32'h0); end
    step(1);
    n_cmp++; if ({hi2, lo2} !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL div2_neg: got %h want %h", {hi2, lo2}, 64'hFFFFFFFF_FFFFFFFD); end
    n_cmp++; if (done2 !== 1'b1) begin n_bad++; $display("FAIL div2_done: got %b want 1", done2); end
    step(15);
    n_cmp++; if ({busy1, lo1} !== {1'b1, 32'h00000001}) begin n_bad++; $display("FAIL div1_early: got %b %h want 1 %h", busy1, lo1, 32'h1); end
    step(1);
    n_cmp++; if ({hi1, lo1} !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL div1_neg: got %h want %h", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFFD); end
    n_cmp++; if (done1 !== 1'b1) begin n_bad++; $display("FAIL div1_done: got %b want 1", done1); end
    // MIN / -1 wraps
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    step(17);
    n_cmp++; if ({hi2, lo2} !== 64'h00000000_80000000) begin n_bad++; $display("FAIL div2_min: got %h want %h", {hi2, lo2}, 64'h80000000); end
    step(16);
    n_cmp++; if ({hi1, lo1} !== 64'h00000000_80000000) begin n_bad++; $display("FAIL div1_min: got %h want %h", {hi1, lo1}, 64'h80000000); end
    // Unsigned 100 / 7
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
    step(17);
    n_cmp++; if ({hi2, lo2} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL divu2: got %h want %h", {hi2, lo2}, {32'd2, 32'd14}); end
  endtask

  task automatic test_div_zero;
    issue(OP_DIVU, 32'h55, 32'h0, 1'b1, 1'b0);
    n_cmp++; if ({busy1, div_zero1} !== 2'b10) begin n_bad++; $display("FAIL dz_pending: got %b want 10", {busy1, div_zero1}); end
    step(1);
    n_cmp++; if ({hi1, lo1} !== 64'h00000055_FFFFFFFF) begin n_bad++; $display("FAIL dz_result: got %h want %h", {hi1, lo1}, 64'h00000055_FFFFFFFF); end
    n_cmp++; if ({div_zero1, done1, busy1} !== 3'b110) begin n_bad++; $display("FAIL dz_flags: got %b want 110", {div_zero1, done1, busy1}); end
    step(2);
    n_cmp++; if (div_zero1 !== 1'b1) begin n_bad++; $display("FAIL dz_sticky: got %b want 1", div_zero1); end
    issue(OP_MTLO, 32'h1, 32'h0, 1'b1, 1'b0);
    n_cmp++; if ({div_zero1, lo1} !== {1'b0, 32'h1}) begin n_bad++; $display("FAIL dz_clear: got %b %h want 0 %h", div_zero1, lo1, 32'h1); end
  endtask

  task automatic test_cancel;
    int d0;
    d0 = done1_cnt;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    step(9);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL cancel_busy: got %b want 0", busy1); end
    step(40);
    n_cmp++; if ({hi1, lo1} !== 64'h00000055_00000001) begin n_bad++; $display("FAIL cancel_hilo: got %h want %h", {hi1, lo1}, 64'h00000055_00000001); end
    n_cmp++; if (done1_cnt - d0 !== 0) begin n_bad++; $display("FAIL cancel_done: got %0d want 0", done1_cnt - d0); end
    // Cancel while in FIX still suppresses the write
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    step(32);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(2);
    n_cmp++; if ({busy1, hi1, lo1} !== {1'b0, 64'h00000055_00000001}) begin n_bad++; $display("FAIL cancel_fix: got %b %h want 0 %h", busy1, {hi1, lo1}, 64'h00000055_00000001); end
    n_cmp++; if (done1_cnt - d0 !== 0) begin n_bad++; $display("FAIL cancel_fix_done: got %0d want 0", done1_cnt - d0); end
    // in_valid with cancel in IDLE is not accepted
    op = OP_MTHI; a = 32'hDEADBEEF; in_valid1 = 1'b1; cancel = 1'b1;
    step(1);
    in_valid1 = 1'b0; cancel = 1'b0;
    step(1);
    n_cmp++; if (hi1 !== 32'h00000055) begin n_bad++; $display("FAIL cancel_idle: got %h want %h", hi1, 32'h55); end
  endtask

  task automatic test_back_pressure;
    issue(OP_MULTU, 32'd5, 32'd6, 1'b1, 1'b0);
    op = OP_MTHI; a = 32'h00000BAD; in_valid1 = 1'b1;
    n_cmp++; if (in_ready1 !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b want 0", in_ready1); end
    step(1);
    in_valid1 = 1'b0;
    step(1);
    n_cmp++; if ({hi1, lo1} !== {32'd0, 32'd30}) begin n_bad++; $display("FAIL bp_result: got %h want %h", {hi1, lo1}, {32'd0, 32'd30}); end
    step(2);
    n_cmp++; if ({busy1, hi1} !== {1'b0, 32'd0}) begin n_bad++; $display("FAIL bp_ignored: got %b %h want 0 %h", busy1, hi1, 32'd0); end
  endtask

  task automatic test_reset_mid_op;
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b1, 1'b0);
    step(3);
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({busy1, hi1, lo1} !== {1'b0, 64'h0}) begin n_bad++; $display("FAIL reset_mid: got %b %h want 0 %h", busy1, {hi1, lo1}, 64'h0); end
    step(1);
    reset_n = 1'b1;
    step(40);
    n_cmp++; if ({busy1, hi1, lo1} !== {1'b0, 64'h0}) begin n_bad++; $display("FAIL reset_discard: got %b %h want 0 %h", busy1, {hi1, lo1}, 64'h0); end
  endtask

  initial begin
    in_valid1 = 1'b0; in_valid2 = 1'b0; cancel = 1'b0;
    op = 4'h0; a = 32'h0; b = 32'h0; reset_n = 1'b0;
    test_reset;
    test_mt;
    test_mult_madd;
    test_mul_variants;
    test_div;
    test_div_zero;
    test_cancel;
    test_back_pressure;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
